// File: rtl/mem_address_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_address_unit
// Brief    : Registered memory-address selector with an exception-vector
//            sequencer. Normal loads choose between the ALU result, the ALUOut
//            register or a vector constant. Exception requests are latched,
//            served lowest-index first, and held for MEM_LAT wait cycles.
//            A one-cycle done pulse then goes to the control unit.
// Revision : 1.0 - initial release
// ============================================================================
module mem_address_unit #(
  parameter int WIDTH    = 32,
  parameter int VEC_BASE = 253,
  parameter int N_VEC    = 3,
  parameter int MEM_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       seletor,
  input  logic [WIDTH-1:0] ula_result,
  input  logic [WIDTH-1:0] ulaout_data,
  input  logic             addr_load,
  input  logic [N_VEC-1:0] exc_req,
  output logic [WIDTH-1:0] mem_address_out,
  output logic             exc_busy,
  output logic [2:0]       exc_code,
  output logic             vec_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VEC  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [N_VEC-1:0] r_pending;
  logic [N_VEC-1:0] w_req;
  logic [N_VEC-1:0] w_clr;
  logic [2:0]       w_k;
  logic             w_any;
  logic             w_take;
  logic [WIDTH-1:0] w_vec_addr;
  logic [WIDTH-1:0] w_sel_addr;

  assign w_req  = r_pending | exc_req;
  assign w_any  = |w_req;
  assign w_take = (r_state == S_IDLE) && w_any;

  // Lowest-index request wins; also build the mask of the bit being served.
  always_comb begin
    w_k   = 3'd0;
    w_clr = '0;
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (w_req[i]) w_k = 3'(i);
    end
    for (int i = 0; i < N_VEC; i++) begin
      w_clr[i] = w_take && (w_k == 3'(i));
    end
  end

  assign w_vec_addr = WIDTH'(VEC_BASE) + WIDTH'(w_k);

  // Normal-mode source map; unused codes select zero.
  always_comb begin
    w_sel_addr = '0;
    case (seletor)
      3'b000:  w_sel_addr = ula_result;
      3'b001:  w_sel_addr = ulaout_data;
      default: begin
        if ((int'(seletor) - 2) < N_VEC)
          w_sel_addr = WIDTH'(VEC_BASE) + WIDTH'(seletor - 3'd2);
      end
    endcase
  end

  // Next-state and wait-counter logic of the vector sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_VEC;
      S_VEC: begin
        w_cnt_nxt   = 4'(MEM_LAT - 1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, wait counter and pending-request register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_req & ~w_clr;
    end
  end

  // Address/code register: exception entry beats a normal load; held while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_address_out <= '0;
      exc_code        <= 3'd0;
    end else if (w_take) begin
      mem_address_out <= w_vec_addr;
      exc_code        <= w_k;
    end else if ((r_state == S_IDLE) && addr_load) begin
      mem_address_out <= w_sel_addr;
    end
  end

  assign exc_busy = (r_state != S_IDLE);
  assign vec_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_address_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_address_unit
// Brief    : Self-checking bench. Two instances (MEM_LAT=1 and MEM_LAT=3)
//            share stimulus and are compared against a cycle-level
//            behavioural model of the exception sequence timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_address_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  seletor;
  logic [31:0] ula_result;
  logic [31:0] ulaout_data;
  logic        addr_load;
  logic [2:0]  exc_req;

  logic [31:0] addr_a, addr_b;
  logic        busy_a, busy_b;
  logic [2:0]  code_a, code_b;
  logic        done_a, done_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: address, code, pending mask, and position in the
  // sequence timeline (0 = idle, 1 = vector cycle, ML+2 = done cycle).
  logic [31:0] m_addr [2];
  int          m_code [2];
  int          m_pend [2];
  int          m_seq  [2];

  mem_address_unit #(.WIDTH(32), .VEC_BASE(253), .N_VEC(3), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .seletor(seletor), .ula_result(ula_result),
    .ulaout_data(ulaout_data), .addr_load(addr_load), .exc_req(exc_req),
    .mem_address_out(addr_a), .exc_busy(busy_a), .exc_code(code_a), .vec_done(done_a)
  );

  mem_address_unit #(.WIDTH(32), .VEC_BASE(253), .N_VEC(3), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .seletor(seletor), .ula_result(ula_result),
    .ulaout_data(ulaout_data), .addr_load(addr_load), .exc_req(exc_req),
    .mem_address_out(addr_b), .exc_busy(busy_b), .exc_code(code_b), .vec_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] src_value(input logic [2:0] sel);
    if (sel == 3'd0) return ula_result;
    if (sel == 3'd1) return ulaout_data;
    if (int'(sel) - 2 < 3) return 32'(253 + int'(sel) - 2);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 32'd0;
      m_code[i] = 0;
      m_pend[i] = 0;
      m_seq[i]  = 0;
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_tick();
    int req;
    int k;
    for (int i = 0; i < 2; i++) begin
      req = m_pend[i] | int'(exc_req);
      if (m_seq[i] == 0) begin
        if (req != 0) begin
          k = 0;
          while (((req >> k) & 1) == 0) k++;
          m_addr[i] = 32'(253 + k);
          m_code[i] = k;
          m_pend[i] = req & ~(1 << k);
          m_seq[i]  = 1;
        end else begin
          m_pend[i] = req;
          if (addr_load) m_addr[i] = src_value(seletor);
        end
      end else begin
        m_pend[i] = req;
        m_seq[i]  = (m_seq[i] == lat(i) + 2) ? 0 : m_seq[i] + 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " addr_a"}, addr_a, m_addr[0]);
    chk({ph, " busy_a"}, 32'(busy_a), 32'(m_seq[0] != 0));
    chk({ph, " code_a"}, 32'(code_a), 32'(m_code[0]));
    chk({ph, " done_a"}, 32'(done_a), 32'(m_seq[0] == lat(0) + 2));
    chk({ph, " addr_b"}, addr_b, m_addr[1]);
    chk({ph, " busy_b"}, 32'(busy_b), 32'(m_seq[1] != 0));
    chk({ph, " code_b"}, 32'(code_b), 32'(m_code[1]));
    chk({ph, " done_b"}, 32'(done_b), 32'(m_seq[1] == lat(1) + 2));
  endtask

  task automatic step(input string ph);
    if (reset) model_tick();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  initial begin
    reset       = 1'b0;
    seletor     = 3'd0;
    ula_result  = 32'd0;
    ulaout_data = 32'd0;
    addr_load   = 1'b0;
    exc_req     = 3'd0;
    model_reset();

    // Reset state
    step("reset");
    step("reset");
    reset = 1'b1;

    // Normal load from ula_result, then hold
    seletor = 3'd0; ula_result = 32'h1234; addr_load = 1'b1;
    step("load_ula");
    chk("load_ula_direct", addr_a, 32'h1234);
    addr_load = 1'b0; ula_result = 32'h5678;
    step("hold");
    chk("hold_direct", addr_a, 32'h1234);

    // Remaining source codes
    ulaout_data = 32'hCAFE_0001; addr_load = 1'b1;
    for (int s = 1; s < 8; s++) begin
      seletor = 3'(s);
      step("srcmap");
    end
    addr_load = 1'b0;

    // Two pending requests served back-to-back
    exc_req = 3'b110;
    step("exc110");
    chk("exc110_addr_direct", addr_a, 32'd254);
    exc_req = 3'b000;
    for (int c = 0; c < 16; c++) step("exc110_seq");
    chk("exc110_last_code", 32'(code_a), 32'd2);

    // Exception entry beats addr_load in the same cycle
    exc_req = 3'b001; seletor = 3'd0; addr_load = 1'b1; ula_result = 32'h0BAD;
    step("exc_vs_load");
    chk("exc_vs_load_direct", addr_a, 32'd253);
    exc_req = 3'b000;
    for (int c = 0; c < 8; c++) step("exc_vs_load_seq");

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      seletor     = 3'($urandom_range(0, 7));
      ula_result  = $urandom;
      ulaout_data = $urandom;
      addr_load   = 1'($urandom_range(0, 1));
      exc_req     = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
      step("random");
    end
    exc_req = 3'd0; addr_load = 1'b0;
    for (int c = 0; c < 30; c++) step("drain");

    // Reset while both instances are in the wait phase
    exc_req = 3'b001;
    step("abort_entry");
    exc_req = 3'b100;
    step("abort_wait");
    exc_req = 3'b000;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("abort_async");
    step("abort_hold");
    reset = 1'b1;
    for (int c = 0; c < 8; c++) step("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
